// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the HD44780 frame driver.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
    localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
    localparam logic [7:0] CMD_DISP_BLINK = 8'h0F;
    localparam logic [7:0] CMD_ENTRY      = 8'h06;
    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_LINE1      = 8'h80;
    localparam logic [7:0] CMD_LINE2      = 8'hC0;

    localparam int LCD_CHARS = 32;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        ADDR1,
        LINE1,
        ADDR2,
        LINE2,
        DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_EHIGH,
        PH_HOLD
    } phase_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_write_cycle.sv
// One LCD bus write: SETUP (rs/data settle), EHIGH (strobe), HOLD (command
// execution time). Assumes SETUP_CYC >= 2 so data can be latched late in SETUP.
module lcd_write_cycle
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC    = 2,
    parameter int E_PULSE_CYC  = 12,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 80000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);

    localparam int MAX_CYC = max_int(max_int(SETUP_CYC, E_PULSE_CYC),
                                     max_int(CMD_WAIT_CYC, CLR_WAIT_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EHIGH_LD = CNT_W'(E_PULSE_CYC - 1);
    // The idle cycle in which the sequencer issues the next start is the last
    // cycle of the wait, so HOLD itself is one cycle shorter than the wait.
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 2);
    localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYC - 2);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    phase_t           phase;
    logic [CNT_W-1:0] cnt;
    logic             long_r;

    assign done = (phase == PH_HOLD) && (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase    <= PH_IDLE;
            cnt      <= '0;
            long_r   <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (start) begin
                        phase  <= PH_SETUP;
                        cnt    <= SETUP_LD;
                        lcd_rs <= rs;
                        long_r <= long_wait;
                    end
                end
                PH_SETUP: begin
                    // Latch one cycle before E rises; char_in has had time to settle.
                    if (cnt == ONE) begin
                        lcd_data <= data;
                    end
                    if (cnt == '0) begin
                        phase <= PH_EHIGH;
                        cnt   <= EHIGH_LD;
                        lcd_e <= 1'b1;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                PH_EHIGH: begin
                    if (cnt == '0) begin
                        phase <= PH_HOLD;
                        cnt   <= long_r ? CLR_LD : CMD_LD;
                        lcd_e <= 1'b0;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                PH_HOLD: begin
                    if (cnt == '0) begin
                        phase <= PH_IDLE;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_frame_driver.sv
// Frame sequencer for a 16x2 HD44780 LCD: power-on wait, init, then endless
// refresh of 32 characters. Define LCD_CURSOR_BLINK_EN for cursor-on/blink.
module lcd_frame_driver
    import lcd_pkg::*;
#(
    parameter int PWR_WAIT_CYC = 16,
    parameter int SETUP_CYC    = 2,
    parameter int E_PULSE_CYC  = 12,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 80000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [4:0] index,
    input  logic [7:0] char_in,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       frame_done
);

`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] DISP_CMD = CMD_DISP_BLINK;
`else
    localparam logic [7:0] DISP_CMD = CMD_DISP_ON;
`endif

    localparam int PWR_W = $clog2(PWR_WAIT_CYC) + 1;
    // The start-issue cycle counts toward the power-on wait.
    localparam logic [PWR_W-1:0] PWR_LD = PWR_W'(PWR_WAIT_CYC - 2);

    localparam logic [4:0] LAST1  = 5'(LCD_CHARS / 2 - 1);
    localparam logic [4:0] FIRST2 = 5'(LCD_CHARS / 2);
    localparam logic [4:0] LAST2  = 5'(LCD_CHARS - 1);

    seq_state_t       state, state_nx;
    logic [1:0]       step, step_nx;
    logic [PWR_W-1:0] pwr_cnt, pwr_nx;
    logic [4:0]       index_nx;
    logic             start_r, start_nx;
    logic             fd_nx;
    logic             wc_done;
    logic             wr_rs;
    logic             wr_long;
    logic [7:0]       wr_data;

    assign lcd_rw = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= PWR_WAIT;
            step       <= 2'd0;
            pwr_cnt    <= PWR_LD;
            index      <= 5'd0;
            start_r    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            step       <= step_nx;
            pwr_cnt    <= pwr_nx;
            index      <= index_nx;
            start_r    <= start_nx;
            frame_done <= fd_nx;
        end
    end

    always_comb begin
        state_nx = state;
        step_nx  = step;
        pwr_nx   = pwr_cnt;
        case (state)
            PWR_WAIT: begin
                if (pwr_cnt == '0) state_nx = INIT;
                else               pwr_nx   = pwr_cnt - PWR_W'(1);
            end
            INIT: begin
                if (wc_done) begin
                    if (step == 2'd3) state_nx = ADDR1;
                    else              step_nx  = step + 2'd1;
                end
            end
            ADDR1:   if (wc_done) state_nx = LINE1;
            LINE1:   if (wc_done && index == LAST1) state_nx = ADDR2;
            ADDR2:   if (wc_done) state_nx = LINE2;
            LINE2:   if (wc_done && index == LAST2) state_nx = DONE;
            DONE:    state_nx = ADDR1;
            default: state_nx = PWR_WAIT;
        endcase
    end

    // The next write is started in the same cycle the previous one finishes,
    // so index moves one cycle ahead of the write-cycle SETUP.
    always_comb begin
        start_nx = wc_done || (state == PWR_WAIT && pwr_cnt == '0);
        index_nx = index;
        fd_nx    = 1'b0;
        wr_rs    = 1'b0;
        wr_long  = 1'b0;
        wr_data  = CMD_LINE1;
        case (state)
            INIT: begin
                wr_long = (step == 2'd3);
                case (step)
                    2'd0:    wr_data = CMD_FUNC_SET;
                    2'd1:    wr_data = DISP_CMD;
                    2'd2:    wr_data = CMD_ENTRY;
                    default: wr_data = CMD_CLEAR;
                endcase
            end
            ADDR1: begin
                wr_data = CMD_LINE1;
                if (wc_done) index_nx = 5'd0;
            end
            LINE1: begin
                wr_rs   = 1'b1;
                wr_data = char_in;
                if (wc_done && index != LAST1) index_nx = index + 5'd1;
            end
            ADDR2: begin
                wr_data = CMD_LINE2;
                if (wc_done) index_nx = FIRST2;
            end
            LINE2: begin
                wr_rs   = 1'b1;
                wr_data = char_in;
                if (wc_done && index != LAST2) index_nx = index + 5'd1;
                if (wc_done && index == LAST2) fd_nx = 1'b1;
            end
            default: begin
                wr_data = (state == PWR_WAIT) ? CMD_FUNC_SET : CMD_LINE1;
            end
        endcase
    end

    lcd_write_cycle #(
        .SETUP_CYC   (SETUP_CYC),
        .E_PULSE_CYC (E_PULSE_CYC),
        .CMD_WAIT_CYC(CMD_WAIT_CYC),
        .CLR_WAIT_CYC(CLR_WAIT_CYC)
    ) u_wc (
        .clk      (clk),
        .rst      (rst),
        .start    (start_r),
        .rs       (wr_rs),
        .data     (wr_data),
        .long_wait(wr_long),
        .done     (wc_done),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data)
    );

endmodule

// File: tb/tb_lcd_frame_driver.sv
// Scoreboard bench for lcd_frame_driver: expected LCD writes are queued and
// matched against writes captured from the bus at each E strobe.
module tb_lcd_frame_driver;

    localparam int P   = 10;
    localparam int S   = 2;
    localparam int EP  = 3;
    localparam int W   = 5;
    localparam int CLR = 20;
    localparam int PER = S + EP + W;

`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] EXP_DISP = 8'h0F;
`else
    localparam logic [7:0] EXP_DISP = 8'h0C;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] index;
    logic [7:0] char_in = 8'h00;
    logic       lcd_e, lcd_rs, lcd_rw, frame_done;
    logic [7:0] lcd_data;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         rise;
        int         fall;
        bit         stable;
    } obs_t;

    wr_t  expq[$];
    obs_t obsq[$];
    int   fdq[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   rel_cyc = 0;
    int   addr1_rise = 0;
    int   last_fall = 0;

    always #5 clk = ~clk;

    always @(posedge clk) char_in <= 8'h40 + {3'b000, index};

    lcd_frame_driver #(
        .PWR_WAIT_CYC(P),
        .SETUP_CYC   (S),
        .E_PULSE_CYC (EP),
        .CMD_WAIT_CYC(W),
        .CLR_WAIT_CYC(CLR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .index     (index),
        .char_in   (char_in),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data),
        .frame_done(frame_done)
    );

    initial forever @(posedge clk) cyc++;

    // Bus monitor: one record per E pulse, flags any rs/data change while E is high.
    initial begin : monitor
        obs_t cur;
        logic pe;
        pe = 1'b0;
        cur.rs = 1'b0; cur.data = 8'h00; cur.rise = 0; cur.fall = 0; cur.stable = 1'b0;
        forever begin
            @(negedge clk);
            if (lcd_e === 1'b1 && pe !== 1'b1) begin
                cur.rs = lcd_rs; cur.data = lcd_data; cur.rise = cyc; cur.stable = 1'b1;
            end else if (lcd_e === 1'b1) begin
                if (lcd_rs !== cur.rs || lcd_data !== cur.data) cur.stable = 1'b0;
            end else if (pe === 1'b1) begin
                cur.fall = cyc;
                obsq.push_back(cur);
            end
            if (frame_done === 1'b1) fdq.push_back(cyc);
            pe = lcd_e;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input logic rs, input logic [7:0] data);
        wr_t e;
        e.rs = rs; e.data = data;
        expq.push_back(e);
    endtask

    task automatic push_lines();
        for (int i = 0; i < 16; i++) push_exp(1'b1, 8'h40 + 8'(i));
        push_exp(1'b0, 8'hC0);
        for (int i = 16; i < 32; i++) push_exp(1'b1, 8'h40 + 8'(i));
    endtask

    task automatic next_obs(output obs_t o, output bit ok);
        ok = 1'b0;
        o.rs = 1'b0; o.data = 8'h00; o.rise = 0; o.fall = 0; o.stable = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (obsq.size() > 0) begin
                o = obsq.pop_front();
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bit seen;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (lcd_e !== 1'b0)      begin errors++; $display("FAIL rst_e: got %b want 0", lcd_e); end
        checks++; if (lcd_rs !== 1'b0)     begin errors++; $display("FAIL rst_rs: got %b want 0", lcd_rs); end
        checks++; if (lcd_rw !== 1'b0)     begin errors++; $display("FAIL rst_rw: got %b want 0", lcd_rw); end
        checks++; if (lcd_data !== 8'h00)  begin errors++; $display("FAIL rst_data: got %h want 00", lcd_data); end
        checks++; if (index !== 5'd0)      begin errors++; $display("FAIL rst_index: got %0d want 0", index); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd: got %b want 0", frame_done); end
        @(negedge clk);
        rst = 1'b1;
        rel_cyc = cyc;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (obsq.size() > 0) begin seen = 1'b1; break; end
            @(negedge clk); #1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL first_write: no E pulse within 100 cycles of reset release");
        end else begin
            checks++;
            if (obsq[0].rise - rel_cyc !== P + S) begin
                errors++; $display("FAIL first_rise: E rose %0d cycles after release, want %0d", obsq[0].rise - rel_cyc, P + S);
            end
        end
    endtask

    task automatic test_init();
        int per;
        int prev_rise;
        wr_t e;
        obs_t o;
        bit ok;
        prev_rise = 0;
        push_exp(1'b0, 8'h38);
        push_exp(1'b0, EXP_DISP);
        push_exp(1'b0, 8'h06);
        push_exp(1'b0, 8'h01);
        push_exp(1'b0, 8'h80);
        for (int k = 0; k < 5; k++) begin
            e = expq.pop_front();
            next_obs(o, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL init_timeout: write %0d never seen", k); break; end
            checks++;
            if (o.rs !== e.rs || o.data !== e.data) begin
                errors++; $display("FAIL init_write%0d: got rs=%b data=%h want rs=%b data=%h", k, o.rs, o.data, e.rs, e.data);
            end
            checks++;
            if (o.fall - o.rise !== EP) begin
                errors++; $display("FAIL init_pulse%0d: E high %0d cycles want %0d", k, o.fall - o.rise, EP);
            end
            if (k > 0) begin
                per = (k == 4) ? S + EP + CLR : PER;
                checks++;
                if (o.rise - prev_rise !== per) begin
                    errors++; $display("FAIL init_period%0d: got %0d want %0d", k, o.rise - prev_rise, per);
                end
            end
            prev_rise = o.rise;
            if (k == 4) addr1_rise = o.rise;
        end
    endtask

    task automatic test_lines();
        int prev_rise;
        wr_t e;
        obs_t o;
        bit ok;
        prev_rise = addr1_rise;
        push_lines();
        for (int k = 0; k < 33; k++) begin
            e = expq.pop_front();
            next_obs(o, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL line_timeout: write %0d never seen", k); break; end
            checks++;
            if (o.rs !== e.rs || o.data !== e.data) begin
                errors++; $display("FAIL line_write%0d: got rs=%b data=%h want rs=%b data=%h", k, o.rs, o.data, e.rs, e.data);
            end
            checks++;
            if (!o.stable) begin errors++; $display("FAIL line_stable%0d: rs/data changed while E high (got 1 want 0 changes)", k); end
            checks++;
            if (o.rise - prev_rise !== PER) begin
                errors++; $display("FAIL line_period%0d: got %0d want %0d", k, o.rise - prev_rise, PER);
            end
            prev_rise = o.rise;
            last_fall = o.fall;
        end
    endtask

    task automatic test_frame_done();
        repeat (W + 1) @(negedge clk);
        #1;
        checks++;
        if (fdq.size() !== 1) begin
            errors++; $display("FAIL fd_count: got %0d pulses want 1", fdq.size());
        end else begin
            checks++;
            if (fdq[0] - last_fall !== W - 1) begin
                errors++; $display("FAIL fd_time: pulse %0d cycles after E fall want %0d", fdq[0] - last_fall, W - 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int prev_rise;
        wr_t e;
        obs_t o;
        bit ok;
        prev_rise = 0;
        push_exp(1'b0, 8'h80);
        push_lines();
        for (int k = 0; k < 34; k++) begin
            e = expq.pop_front();
            next_obs(o, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL frame2_timeout: write %0d never seen", k); break; end
            checks++;
            if (o.rs !== e.rs || o.data !== e.data) begin
                errors++; $display("FAIL frame2_write%0d: got rs=%b data=%h want rs=%b data=%h", k, o.rs, o.data, e.rs, e.data);
            end
            if (k == 0) begin
                checks++;
                if (o.rise - addr1_rise !== 34 * PER) begin
                    errors++; $display("FAIL frame_period: got %0d want %0d", o.rise - addr1_rise, 34 * PER);
                end
            end else begin
                checks++;
                if (o.rise - prev_rise !== PER) begin
                    errors++; $display("FAIL frame2_period%0d: got %0d want %0d", k, o.rise - prev_rise, PER);
                end
            end
            prev_rise = o.rise;
        end
        repeat (W + 1) @(negedge clk);
        #1;
        checks++;
        if (fdq.size() !== 2) begin errors++; $display("FAIL fd_count2: got %0d pulses want 2", fdq.size()); end
    endtask

    task automatic test_reset_mid();
        bit found;
        obs_t o;
        bit ok;
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (lcd_e === 1'b1 && index === 5'd20) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL mid_find: E-high of index 20 not reached");
        end else begin
            #2 rst = 1'b0;
            #1;
            checks++; if (lcd_e !== 1'b0)     begin errors++; $display("FAIL mid_e: got %b want 0", lcd_e); end
            checks++; if (lcd_data !== 8'h00) begin errors++; $display("FAIL mid_data: got %h want 00", lcd_data); end
            checks++; if (index !== 5'd0)     begin errors++; $display("FAIL mid_index: got %0d want 0", index); end
            checks++; if (lcd_rs !== 1'b0)    begin errors++; $display("FAIL mid_rs: got %b want 0", lcd_rs); end
            repeat (3) @(negedge clk);
            #1;
            obsq.delete(); fdq.delete(); expq.delete();
            @(negedge clk);
            rst = 1'b1;
            rel_cyc = cyc;
            push_exp(1'b0, 8'h38);
            push_exp(1'b0, EXP_DISP);
            for (int k = 0; k < 2; k++) begin
                wr_t e;
                e = expq.pop_front();
                next_obs(o, ok);
                checks++;
                if (!ok) begin errors++; $display("FAIL restart_timeout: write %0d never seen", k); break; end
                checks++;
                if (o.rs !== e.rs || o.data !== e.data) begin
                    errors++; $display("FAIL restart_write%0d: got rs=%b data=%h want rs=%b data=%h", k, o.rs, o.data, e.rs, e.data);
                end
                if (k == 0) begin
                    checks++;
                    if (o.rise - rel_cyc !== P + S) begin
                        errors++; $display("FAIL restart_rise: got %0d want %0d", o.rise - rel_cyc, P + S);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_lines();
        test_frame_done();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
